regfile_mp_sb: RTL

- Parametrised two-read/two-write register file for the MIPS datapath. Successor to the single-write register file.
- Write port A is ALU/execute writeback; write port B is load writeback.
- Adds hardwired zero register, same-cycle write-to-read bypass, a per-register pending-load scoreboard for stall generation, write-collision detection and a parametrised debug tap.
- Sits between decode (reads, pend_set) and writeback (writes).

---
 rtl/regfile_mp_sb.sv | 89 ++++++++
 1 files changed

// File: rtl/regfile_mp_sb.sv
// Two-read/two-write MIPS register file with hardwired zero, write-to-read
// bypass, pending-load scoreboard, write-collision flag and a debug tap.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int TAP_REG  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic              wr_collide,
  output logic [DATA_W-1:0] tap_data
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] TAP_IDX = ADDR_W'(TAP_REG);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pend_q, pend_d;
  logic              wr_collide_q, wr_collide_d;
  logic              wa_ok, wb_ok;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Read priority: hardwired zero, then port A forward, then port B forward.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] arr);
    if (is_zero(a))                                return '0;
    else if ((BYPASS != 0) && wa_en && wa_addr == a) return wa_data;
    else if ((BYPASS != 0) && wb_en && wb_addr == a) return wb_data;
    else                                           return arr;
  endfunction

  function automatic logic busy_port(input logic [ADDR_W-1:0] a, input logic p);
    return p && !((BYPASS != 0) && wb_en && wb_addr == a);
  endfunction

  always_comb begin
    wa_ok        = wa_en && !is_zero(wa_addr);
    wb_ok        = wb_en && !is_zero(wb_addr);
    regs_d       = regs_q;
    pend_d       = pend_q;
    wr_collide_d = wa_ok && wb_ok && (wa_addr == wb_addr);
    // Port B first so port A overwrites it on a collision.
    if (wb_ok) regs_d[wb_addr] = wb_data;
    if (wa_ok) regs_d[wa_addr] = wa_data;
    // Clear before set: a fresh load issued this cycle keeps the bit set.
    if (wb_en) pend_d[wb_addr] = 1'b0;
    if (pend_set && !is_zero(pend_addr)) pend_d[pend_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pend_q       <= '0;
      wr_collide_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      pend_q       <= pend_d;
      wr_collide_q <= wr_collide_d;
    end
  end

  assign rs_data    = read_port(rs_addr, regs_q[rs_addr]);
  assign rt_data    = read_port(rt_addr, regs_q[rt_addr]);
  assign rs_busy    = busy_port(rs_addr, pend_q[rs_addr]);
  assign rt_busy    = busy_port(rt_addr, pend_q[rt_addr]);
  assign wr_collide = wr_collide_q;
  assign tap_data   = regs_q[TAP_IDX];

endmodule
